led_pulse_driver: RTL and testbench
===================================

Name: led_pulse_driver

Overview:
- Output-side counterpart to the button input synchroniser in the external-signal lab.
- Converts single-cycle internal event pulses, synchronous to SYS_CLK, into human-visible LED pulses on a board pin such as LD0.
- Each event produces one pulse with a guaranteed minimum on-time and off-time.
- Events that arrive while a pulse is in progress are queued in a saturating pending counter. None are lost until the counter saturates.

Parameters:
- ON_CYCLES, 12500000, LED high time in SYS_CLK cycles (100 ms at 125 MHz). Must be >= 1.
- OFF_CYCLES, 12500000, minimum LED low gap between consecutive pulses, in cycles. Must be >= 1.
- PEND_W, 4, width of the pending-event counter. Saturates at 2^PEND_W-1.

Ports:
- SYS_CLK  input  1  system clock, 125 MHz.
- SYS_RST  input  1  synchronous, active-high reset.
- EVT_IN  input  1  event strobe, already synchronous to SYS_CLK. Each high cycle counts as one event.
- EN  input  1  when low, no new pulse starts. A pulse in progress completes.
- LED_OUT  output  1  registered LED drive, active high.
- BUSY  output  1  high in the ON or OFF state.
- PEND_CNT  output  PEND_W  number of queued events not yet started.
- OVERFLOW  output  1  sticky flag: an event was dropped because PEND_CNT was saturated.

Behaviour:
- Clocking and reset:
  - One clock domain; every flop is clocked by SYS_CLK.
  - SYS_RST is synchronous and active-high.
  - Reset values: LED_OUT=0, BUSY=0, PEND_CNT=0, OVERFLOW=0, state=IDLE, timer=0.
  - Reset mid-pulse forces LED_OUT low at the next edge and discards all queued events.
  - All outputs are registered; none is combinational from an input.
- States: IDLE, ON, OFF. The down-timer is sized to max(ON_CYCLES, OFF_CYCLES).
- IDLE -> ON:
  - Condition: EN=1 and (PEND_CNT!=0 or EVT_IN=1).
  - At the next edge: LED_OUT=1, BUSY=1, timer loaded with ON_CYCLES-1.
  - Latency: EVT_IN high at edge N in IDLE with PEND_CNT=0 gives LED_OUT=1 after edge N+1. PEND_CNT stays 0.
- ON: timer decrements each cycle. When the timer reaches 0 -> OFF, with LED_OUT=0 and timer loaded with OFF_CYCLES-1. LED_OUT is therefore high for exactly ON_CYCLES cycles.
- OFF: timer decrements each cycle. When the timer reaches 0:
  - if EN=1 and (PEND_CNT!=0 or EVT_IN=1) -> ON directly, so the gap is exactly OFF_CYCLES;
  - otherwise -> IDLE with BUSY=0.
- Pending counter, evaluated each edge with "start" meaning an ON entry on that edge:
  - next = PEND_CNT + EVT_IN - start.
  - Simultaneous event and start: the count is unchanged (the event is consumed directly).
  - EVT_IN high for k consecutive cycles queues k events.
- Saturation:
  - If PEND_CNT = 2^PEND_W-1, EVT_IN=1 and no start on that edge: the event is dropped, PEND_CNT holds, and OVERFLOW is set.
  - OVERFLOW clears only on SYS_RST.
- EN=0:
  - Events are still counted.
  - ON and OFF run to completion.
  - No ON entry occurs; the FSM parks in IDLE.
  - When EN returns high, queued pulses resume, with the first one starting on the next edge.
- Arithmetic: the timer and counter are unsigned and never wrap. The counter saturates at both ends, and a decrement only occurs when PEND_CNT!=0 or EVT_IN=1.

Test Plan:
Common bench parameters: ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
- Reset/single event: hold SYS_RST for 5 cycles, then a 1-cycle EVT_IN -> all outputs are 0 through reset. LED_OUT is high for exactly 4 cycles starting the cycle after EVT_IN, followed by 3 cycles of BUSY=1 with LED low, then IDLE. PEND_CNT stays 0.
- Back-to-back queueing: 3 EVT_IN pulses on consecutive cycles -> PEND_CNT reads 1 then 2. Three LED pulses of 4 high / 3 low with no extra idle cycle between them. PEND_CNT returns to 0. OVERFLOW=0.
- Saturation: 5 consecutive EVT_IN cycles from IDLE -> the first starts a pulse, PEND_CNT=3 after the 4th event, the 5th sets OVERFLOW=1 and is dropped. Exactly 4 pulses are emitted. OVERFLOW stays 1 until SYS_RST.
- Simultaneous event/start: EVT_IN on the final OFF cycle with PEND_CNT=1 -> a pulse starts and PEND_CNT remains 1.
- Enable gating: EN=0, 2 events -> PEND_CNT=2 and LED_OUT=0. Raise EN -> LED_OUT=1 on the next cycle and two pulses are emitted.
- Reset mid-pulse: assert SYS_RST during the 2nd ON cycle with PEND_CNT=2 -> LED_OUT=0, PEND_CNT=0 and BUSY=0 after one edge. No pulse follows after reset is released.

Source files
------------

// File: rtl/led_pulse_driver.sv
// Stretches single-cycle event strobes into visible LED pulses with a fixed on-time and off-gap.
// Events that arrive during a pulse are queued in a saturating pending counter.
module led_pulse_driver #(
    parameter int ON_CYCLES  = 12500000,
    parameter int OFF_CYCLES = 12500000,
    parameter int PEND_W     = 4
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    input  logic              EVT_IN,
    input  logic              EN,
    output logic              LED_OUT,
    output logic              BUSY,
    output logic [PEND_W-1:0] PEND_CNT,
    output logic              OVERFLOW
);

    localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
    localparam logic [PEND_W-1:0]  P_ONE    = PEND_W'(1);
    localparam logic [PEND_W-1:0]  PEND_MAX = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;

    logic [1:0]         r_state;
    logic [TIMER_W-1:0] r_timer;
    logic               r_led;
    logic               r_busy;
    logic [PEND_W-1:0]  r_pend;
    logic               r_ovf;

    logic               w_req;
    logic               w_timerDone;
    logic               w_start;
    logic [1:0]         w_stateNext;
    logic [TIMER_W-1:0] w_timerNext;
    logic [PEND_W-1:0]  w_pendNext;
    logic               w_ovfNext;

    assign w_req       = EN && ((r_pend != '0) || EVT_IN);
    assign w_timerDone = (r_timer == '0);

    always_comb begin
        w_stateNext = r_state;
        w_timerNext = r_timer;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_stateNext = S_ON;
                    w_timerNext = ON_LOAD;
                end
            end
            S_ON: begin
                if (w_timerDone) begin
                    w_stateNext = S_OFF;
                    w_timerNext = OFF_LOAD;
                end else begin
                    w_timerNext = r_timer - T_ONE;
                end
            end
            S_OFF: begin
                // Chaining straight back into ON keeps the gap at exactly OFF_CYCLES.
                if (w_timerDone) begin
                    if (w_req) begin
                        w_stateNext = S_ON;
                        w_timerNext = ON_LOAD;
                    end else begin
                        w_stateNext = S_IDLE;
                    end
                end else begin
                    w_timerNext = r_timer - T_ONE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_timerNext = '0;
            end
        endcase
    end

    assign w_start = (w_stateNext == S_ON) && (r_state != S_ON);

    // An event coinciding with a start is consumed directly and leaves the count alone.
    always_comb begin
        w_pendNext = r_pend;
        w_ovfNext  = r_ovf;
        if (EVT_IN && !w_start) begin
            if (r_pend == PEND_MAX) begin
                w_ovfNext = 1'b1;
            end else begin
                w_pendNext = r_pend + P_ONE;
            end
        end else if (!EVT_IN && w_start && (r_pend != '0)) begin
            w_pendNext = r_pend - P_ONE;
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_led   <= 1'b0;
            r_busy  <= 1'b0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_timer <= w_timerNext;
            r_led   <= (w_stateNext == S_ON);
            r_busy  <= (w_stateNext != S_IDLE);
            r_pend  <= w_pendNext;
            r_ovf   <= w_ovfNext;
        end
    end

    assign LED_OUT  = r_led;
    assign BUSY     = r_busy;
    assign PEND_CNT = r_pend;
    assign OVERFLOW = r_ovf;

endmodule

// File: tb/tb_led_pulse_driver.sv
// Directed bench for led_pulse_driver with ON=4, OFF=3, PEND_W=2; expected values hand-derived per cycle.
module tb_led_pulse_driver;

    localparam int ON_C  = 4;
    localparam int OFF_C = 3;

    logic       sysClk;
    logic       sysRst;
    logic       evtIn;
    logic       enIn;
    logic       ledOut;
    logic       busyOut;
    logic [1:0] pendCnt;
    logic       overflowOut;

    int compareCount = 0;
    int failCount    = 0;

    led_pulse_driver #(
        .ON_CYCLES (ON_C),
        .OFF_CYCLES(OFF_C),
        .PEND_W    (2)
    ) dut (
        .SYS_CLK (sysClk),
        .SYS_RST (sysRst),
        .EVT_IN  (evtIn),
        .EN      (enIn),
        .LED_OUT (ledOut),
        .BUSY    (busyOut),
        .PEND_CNT(pendCnt),
        .OVERFLOW(overflowOut)
    );

    initial sysClk = 1'b0;
    always #4 sysClk = ~sysClk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input int expLed, input int expBusy, input int expPend,
                            input int expOvf, input string tag);
        checkOutput({tag, ".led"},  int'(ledOut),      expLed);
        checkOutput({tag, ".busy"}, int'(busyOut),     expBusy);
        checkOutput({tag, ".pend"}, int'(pendCnt),     expPend);
        checkOutput({tag, ".ovf"},  int'(overflowOut), expOvf);
    endtask

    // One clock: drive inputs, take the edge, then check the registered outputs 1 ns later.
    task automatic applyStimulus(input logic evtVal, input logic enVal,
                                 input int expLed, input int expBusy, input int expPend,
                                 input int expOvf, input string tag);
        evtIn = evtVal;
        enIn  = enVal;
        @(posedge sysClk);
        #1;
        checkAll(expLed, expBusy, expPend, expOvf, tag);
    endtask

    task automatic applyReset(input int cycles, input string tag);
        sysRst = 1'b1;
        evtIn  = 1'b0;
        enIn   = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge sysClk);
            #1;
            checkAll(0, 0, 0, 0, $sformatf("%s.rst%0d", tag, i));
        end
        sysRst = 1'b0;
    endtask

    task automatic pulseCheck(input int pendVal, input int ovfVal, input string tag);
        for (int i = 0; i < ON_C; i++)
            applyStimulus(1'b0, 1'b1, 1, 1, pendVal, ovfVal, $sformatf("%s.on%0d", tag, i));
        for (int i = 0; i < OFF_C; i++)
            applyStimulus(1'b0, 1'b1, 0, 1, pendVal, ovfVal, $sformatf("%s.off%0d", tag, i));
    endtask

    task automatic restOfPulse(input int pendVal, input int ovfVal, input string tag);
        for (int i = 1; i < ON_C; i++)
            applyStimulus(1'b0, 1'b1, 1, 1, pendVal, ovfVal, $sformatf("%s.on%0d", tag, i));
        for (int i = 0; i < OFF_C; i++)
            applyStimulus(1'b0, 1'b1, 0, 1, pendVal, ovfVal, $sformatf("%s.off%0d", tag, i));
    endtask

    initial begin
        sysRst = 1'b1;
        evtIn  = 1'b0;
        enIn   = 1'b1;

        // Reset and a single event
        applyReset(5, "t1");
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 0, "t1.idle");
        applyStimulus(1'b1, 1'b1, 1, 1, 0, 0, "t1.on0");
        restOfPulse(0, 0, "t1");
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 0, "t1.end");

        // Three back-to-back events
        applyStimulus(1'b1, 1'b1, 1, 1, 0, 0, "t2.on0");
        applyStimulus(1'b1, 1'b1, 1, 1, 1, 0, "t2.on1");
        applyStimulus(1'b1, 1'b1, 1, 1, 2, 0, "t2.on2");
        applyStimulus(1'b0, 1'b1, 1, 1, 2, 0, "t2.on3");
        for (int i = 0; i < OFF_C; i++)
            applyStimulus(1'b0, 1'b1, 0, 1, 2, 0, $sformatf("t2.off%0d", i));
        pulseCheck(1, 0, "t2.p2");
        pulseCheck(0, 0, "t2.p3");
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 0, "t2.end");

        // Saturation: fifth event is dropped and flags overflow
        applyStimulus(1'b1, 1'b1, 1, 1, 0, 0, "t3.e1");
        applyStimulus(1'b1, 1'b1, 1, 1, 1, 0, "t3.e2");
        applyStimulus(1'b1, 1'b1, 1, 1, 2, 0, "t3.e3");
        applyStimulus(1'b1, 1'b1, 1, 1, 3, 0, "t3.e4");
        applyStimulus(1'b1, 1'b1, 0, 1, 3, 1, "t3.e5");
        for (int i = 1; i < OFF_C; i++)
            applyStimulus(1'b0, 1'b1, 0, 1, 3, 1, $sformatf("t3.off%0d", i));
        pulseCheck(2, 1, "t3.p2");
        pulseCheck(1, 1, "t3.p3");
        pulseCheck(0, 1, "t3.p4");
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 1, "t3.end");
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 1, "t3.sticky");
        applyReset(2, "t3");

        // Event on the final OFF cycle with one queued
        applyStimulus(1'b1, 1'b1, 1, 1, 0, 0, "t4.on0");
        applyStimulus(1'b1, 1'b1, 1, 1, 1, 0, "t4.on1");
        applyStimulus(1'b0, 1'b1, 1, 1, 1, 0, "t4.on2");
        applyStimulus(1'b0, 1'b1, 1, 1, 1, 0, "t4.on3");
        for (int i = 0; i < OFF_C; i++)
            applyStimulus(1'b0, 1'b1, 0, 1, 1, 0, $sformatf("t4.off%0d", i));
        applyStimulus(1'b1, 1'b1, 1, 1, 1, 0, "t4.simul");
        restOfPulse(1, 0, "t4.p2");
        pulseCheck(0, 0, "t4.p3");
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 0, "t4.end");

        // Enable gating
        applyStimulus(1'b1, 1'b0, 0, 0, 1, 0, "t5.q1");
        applyStimulus(1'b1, 1'b0, 0, 0, 2, 0, "t5.q2");
        applyStimulus(1'b0, 1'b0, 0, 0, 2, 0, "t5.hold");
        applyStimulus(1'b0, 1'b1, 1, 1, 1, 0, "t5.en");
        restOfPulse(1, 0, "t5.p1");
        pulseCheck(0, 0, "t5.p2");
        applyStimulus(1'b0, 1'b1, 0, 0, 0, 0, "t5.end");

        // Reset during the second ON cycle with two queued
        applyStimulus(1'b1, 1'b0, 0, 0, 1, 0, "t6.q1");
        applyStimulus(1'b1, 1'b0, 0, 0, 2, 0, "t6.q2");
        applyStimulus(1'b1, 1'b1, 1, 1, 2, 0, "t6.on0");
        applyStimulus(1'b0, 1'b1, 1, 1, 2, 0, "t6.on1");
        applyReset(1, "t6");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b1, 0, 0, 0, 0, $sformatf("t6.after%0d", i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
